// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch queue: issues word reads to imem and buffers {instr, pc} for decode.
// Latency: push on the ack edge, head visible on InstrD the cycle after; redirect flushes in the same cycle.
// Backpressure: StallD holds the head; issue is withheld while count plus outstanding would exceed DEPTH.
//
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   PCWrPendingF         - blocks new fetch issue only
//   BranchTakenD/Target  - decode-stage redirect
//   PCSrcW/ResultW       - writeback redirect, wins over the branch
//   StallD               - decode holds the current head entry
//   imem_req/addr        - registered read request, held until imem_ack
//   imem_ack/rdata       - single-cycle response pulse with data
//   InstrD/InstrValidD   - head instruction (NOP_INSTR when empty) and its valid
//   PCPlus8D             - head PC + 8, holds last value while empty
//   FlushE               - high in every redirect cycle
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'hE1A00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrPendingF,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic        InstrValidD,
  output logic [31:0] PCPlus8D,
  output logic        FlushE
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // REQ: request outstanding, its data will be pushed.
  // DROP: request outstanding but a redirect happened after issue; its data is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;

  logic [31:0]   pc, pcNext;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count, countAfterPop;
  logic [31:0]   pcPlus8Q;
  logic [31:0]   headPcPlus8;

  logic          redirect;
  logic [31:0]   redirectPc;
  logic          pop;
  logic          push;
  logic          issue;

  assign redirect   = PCSrcW | BranchTakenD;
  assign redirectPc = PCSrcW ? ResultW : BranchTargetD;
  assign FlushE     = redirect;

  assign InstrValidD = (count != '0);
  // A redirect flushes the queue, so the head is not consumed in that cycle.
  assign pop         = InstrValidD & ~StallD & ~redirect;

  // Nothing is outstanding in IDLE, so only the current pop frees space for the new request.
  assign countAfterPop = count - CW'(pop);

  assign headPcPlus8 = pcMem[rdPtr] + 32'd8;
  assign InstrD      = InstrValidD ? instrMem[rdPtr] : NOP_INSTR;
  assign PCPlus8D    = InstrValidD ? headPcPlus8 : pcPlus8Q;

  // Next-state / datapath control
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    issue     = 1'b0;
    push      = 1'b0;

    case (state)
      IDLE: begin
        if (!PCWrPendingF && !redirect && (countAfterPop < CW'(DEPTH))) begin
          issue     = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          stateNext = IDLE;
          // Data returning in a redirect cycle belongs to the old path.
          if (!redirect) begin
            push   = 1'b1;
            pcNext = pc + 32'd4;
          end
        end else if (redirect) begin
          stateNext = DROP;
        end
      end
      DROP: begin
        // Stale response: discard it and keep the redirected PC.
        if (imem_ack) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (redirect) begin
      pcNext = redirectPc;
    end
  end

  // Fetch state, PC and request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= 32'd0;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      imem_req <= (stateNext != IDLE);
      if (issue) begin
        imem_addr <= pc;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (redirect) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= pc;
    end
  end

  // Last presented PC+8, shown while the queue is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcPlus8Q <= 32'd8;
    end else if (InstrValidD) begin
      pcPlus8Q <= headPcPlus8;
    end
  end

endmodule
